hamming_enc_engine: RTL and testbench
=====================================

// Module: hamming_enc_engine
// PURPOSE
//  Memory-walking SECDED Hamming encoder: the transmit side of the program-2 decoder.
//  On start it reads NUM_WORDS 11-bit messages from data memory, computes p8/p4/p2/p1
//  and overall parity p0, writes each 16-bit codeword back, then raises halt.
//  Sits beside the data memory as a hardware accelerator in place of program 1.
// PARAMETERS
//  NUM_WORDS  15  messages per run (1..127)
//  SRC_BASE   0   byte address of message 0 low byte
//  DST_BASE   30  byte address of codeword 0 low byte
//  ADDR_W     8   data-memory address width
// PORTS
//  CLK        in   1       clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       run request, sampled in IDLE/DONE
//  halt       out  1       run complete; held until next accepted start
//  mem_addr   out  ADDR_W  byte address
//  mem_rd_en  out  1       read strobe; mem_rdata valid the cycle AFTER the strobe
//  mem_rdata  in   8       read data
//  mem_wr_en  out  1       write strobe; memory writes on that CLK edge
//  mem_wdata  out  8       write data
// BEHAVIOUR
//  Layout, word i: mem[SRC+2i]=d[8:1], mem[SRC+2i+1][2:0]=d[11:9] ([7:3] ignored).
//   Output: mem[DST+2i]=cw[7:0], mem[DST+2i+1]=cw[15:8].
//  Codeword: cw={d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}
//   p8=^d[11:5]; p4=^d[11:8]^(^d[4:2]); p2=d11^d10^d7^d6^d4^d3^d1;
//   p1=d11^d9^d7^d5^d4^d2^d1; p0=^d[11:1]^p8^p4^p2^p1 (even parity over all 16 bits).
//  Reset (async, immediate): state=IDLE, idx=0, halt=0, mem_rd_en=0, mem_wr_en=0,
//   mem_addr=0, mem_wdata=0, message regs=0.
//  FSM (one state per cycle):
//   IDLE:   start=1 -> RD_LO, idx=0.
//   RD_LO:  addr=SRC+2idx, rd_en=1 -> RD_HI.
//   RD_HI:  addr=SRC+2idx+1, rd_en=1; capture rdata into d[8:1] -> CAP_HI.
//   CAP_HI: rd_en=0; capture rdata[2:0] into d[11:9] -> WR_LO.
//   WR_LO:  addr=DST+2idx, wr_en=1, wdata=cw[7:0] -> WR_HI.
//   WR_HI:  addr=DST+2idx+1, wr_en=1, wdata=cw[15:8];
//           idx==NUM_WORDS-1 -> DONE, else idx++ -> RD_LO.
//   DONE:   halt=1; start=1 -> halt=0, idx=0, RD_LO (re-run); else stay.
//  Strobes/addr/wdata are combinational from state; rd_en and wr_en never both high.
//  Timing: 5 cycles/word; start sampled at edge k -> first rd_en cycle k+1;
//   halt rises at edge k+1+5*NUM_WORDS (76 for default), one cycle after last write.
//  start in any busy state ignored; no queuing. start held high in DONE re-runs.
//  idx is 7 bits; DST/SRC+2idx+1 computed mod 2^ADDR_W (wraps, no error).
//  Overlapping SRC/DST regions not checked; order is read-then-write per word.
//  Reset mid-run: strobes drop asynchronously; partially written codeword is left as is.
// TESTING
//  1 d=11'h000 all words, start pulse -> every codeword 16'h0000, halt at cycle 76.
//  2 d=11'h7FF -> 16'hFFFF; d=11'h001 -> 16'h000F; d=11'h400 -> 16'h8117.
//  3 hi byte 8'hF8 (garbage in [7:3]), lo 8'h00 -> codeword 16'h0000.
//  4 15 $random messages -> each codeword matches the program-2 good-codeword formula.
//   Feed outputs unflipped to the decoder -> 15/15, MSBs 2'b00.
//  5 start pulsed during word 3 -> ignored, halt still at cycle 76; start in DONE -> halt
//   drops next cycle and the run repeats identically.
//  6 reset_n low during WR_LO of word 5 -> wr_en=0 same cycle, halt=0.
//   After release plus start -> full correct run.

Source files
------------

// File: rtl/hamming_enc_engine.sv
// Memory-walking SECDED Hamming encoder: reads 11-bit messages from data memory, writes
// 16-bit codewords {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0} back, then raises halt.
module hamming_enc_engine #(
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 30,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    output logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StCapHi,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    localparam logic [6:0] LastIdx = 7'(NUM_WORDS - 1);

    state_e      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  d_lo_q;
    logic [2:0]  d_hi_q;

    logic [11:1]       d;
    logic              p8, p4, p2, p1, p0;
    logic [15:0]       cw;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Read data lags its strobe by one cycle, so each byte lands in the state after its read.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            d_lo_q <= '0;
            d_hi_q <= '0;
        end else begin
            if (state_q == StRdHi)  d_lo_q <= mem_rdata;
            if (state_q == StCapHi) d_hi_q <= mem_rdata[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRdLo;
                    idx_d   = '0;
                end
            end
            StRdLo:  state_d = StRdHi;
            StRdHi:  state_d = StCapHi;
            StCapHi: state_d = StWrLo;
            StWrLo:  state_d = StWrHi;
            StWrHi: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = StRdLo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign d  = {d_hi_q, d_lo_q};
    assign p8 = ^d[11:5];
    assign p4 = (^d[11:8]) ^ (^d[4:2]);
    assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    assign cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
    assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});

    always_comb begin
        halt      = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            StRdLo: begin
                mem_addr  = src_addr;
                mem_rd_en = 1'b1;
            end
            StRdHi: begin
                mem_addr  = src_addr + ADDR_W'(1);
                mem_rd_en = 1'b1;
            end
            StWrLo: begin
                mem_addr  = dst_addr;
                mem_wr_en = 1'b1;
                mem_wdata = cw[7:0];
            end
            StWrHi: begin
                mem_addr  = dst_addr + ADDR_W'(1);
                mem_wr_en = 1'b1;
                mem_wdata = cw[15:8];
            end
            StDone:  halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Bench for hamming_enc_engine: byte memory model, Hamming-position reference encoder,
// cycle-exact bus checks, start-while-busy, re-run from DONE and mid-run reset.
module tb_hamming_enc_engine;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       halt;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    logic [7:0]  mem [256];
    logic [10:0] msg [N];
    int n_assert = 0;
    int n_fail   = 0;

    hamming_enc_engine #(
        .NUM_WORDS(N),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .ADDR_W   (8)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .start    (start),
        .halt     (halt),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Reference: classic Hamming(15,11) by bit position, plus overall parity in bit 0.
    function automatic logic [15:0] ref_cw(input logic [10:0] dm);
        logic [15:0] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = dm[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & p) != 0) && (pos != p)) b = b ^ c[pos];
            c[p] = b;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_msgs(input int mode);
        logic [4:0] junk;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       msg[i] = 11'h000;
                default: msg[i] = 11'($urandom);
            endcase
            junk = 5'($urandom);
            if (mode == 0) junk = 5'h00;
            mem[8'(SRC + 2 * i)]     = msg[i][7:0];
            mem[8'(SRC + 2 * i + 1)] = {junk, msg[i][10:8]};
        end
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 2 * N; i++) mem[8'(DST + i)] = 8'hA5;
    endtask

    // Drives one start pulse, then checks every bus cycle against the word/phase schedule.
    task automatic run(input string tag, input int pulse_cycle);
        int          cyc;
        int          halt_cyc;
        int          bus_err;
        int          w;
        int          ph;
        logic [15:0] c;
        logic        er, ew;
        logic [7:0]  ea, ed;
        halt_cyc = 0;
        bus_err  = 0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 5 * N + 20) begin
            if (cyc <= 5 * N) begin
                w  = (cyc - 1) / 5;
                ph = (cyc - 1) % 5;
                c  = ref_cw(msg[w]);
                er = (ph == 0) || (ph == 1);
                ew = (ph == 3) || (ph == 4);
                ea = (ph < 2) ? 8'(SRC + 2 * w + ph) : 8'(DST + 2 * w + ph - 3);
                ed = (ph == 3) ? c[7:0] : c[15:8];
                if (mem_rd_en !== er || mem_wr_en !== ew || halt !== 1'b0 ||
                    ((er || ew) && mem_addr !== ea) || (ew && mem_wdata !== ed)) begin
                    if (bus_err == 0)
                        $display("%s: bus deviation at cycle %0d: rd=%b wr=%b a=%h wd=%h",
                                 tag, cyc, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
                    bus_err++;
                end
            end
            if (halt === 1'b1) begin
                halt_cyc = cyc;
                break;
            end
            start = (cyc == pulse_cycle);
            @(negedge CLK);
            cyc++;
        end
        start = 1'b0;
        check({tag, " bus"}, 32'(bus_err), 32'd0);
        check({tag, " halt cycle"}, 32'(halt_cyc), 32'(5 * N + 1));
        for (int i = 0; i < N; i++) begin
            c = ref_cw(msg[i]);
            check($sformatf("%s cw%0d", tag, i),
                  {16'h0, mem[8'(DST + 2 * i + 1)], mem[8'(DST + 2 * i)]}, {16'h0, c});
        end
    endtask

    // Decoder-side view: every stored codeword must have zero syndrome and even parity.
    task automatic decode_check(input string tag);
        logic [15:0] c;
        logic [3:0]  syn;
        int          good;
        good = 0;
        for (int i = 0; i < N; i++) begin
            c   = {mem[8'(DST + 2 * i + 1)], mem[8'(DST + 2 * i)]};
            syn = '0;
            for (int pos = 1; pos < 16; pos++) if (c[pos]) syn = syn ^ 4'(pos);
            if (syn == 4'd0 && (^c) == 1'b0) good++;
        end
        check({tag, " decode good"}, 32'(good), 32'(N));
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;

        #1;
        check("rst halt", {31'h0, halt}, 32'd0);
        check("rst rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("rst wr_en", {31'h0, mem_wr_en}, 32'd0);
        check("rst addr", {24'h0, mem_addr}, 32'd0);
        check("rst wdata", {24'h0, mem_wdata}, 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
        check("idle halt", {31'h0, halt}, 32'd0);

        // All-zero messages.
        load_msgs(0);
        clear_dst();
        run("zero", 0);

        // Directed corners, including junk in the high byte's unused bits.
        load_msgs(1);
        msg[0] = 11'h7FF; mem[8'(SRC + 0)] = 8'hFF; mem[8'(SRC + 1)] = 8'h07;
        msg[1] = 11'h001; mem[8'(SRC + 2)] = 8'h01; mem[8'(SRC + 3)] = 8'h00;
        msg[2] = 11'h400; mem[8'(SRC + 4)] = 8'h00; mem[8'(SRC + 5)] = 8'h04;
        msg[3] = 11'h000; mem[8'(SRC + 6)] = 8'h00; mem[8'(SRC + 7)] = 8'hF8;
        clear_dst();
        run("dir", 0);
        check("dir 7FF", {16'h0, mem[8'(DST + 1)], mem[8'(DST + 0)]}, 32'h0000FFFF);
        check("dir 001", {16'h0, mem[8'(DST + 3)], mem[8'(DST + 2)]}, 32'h0000000F);
        check("dir 400", {16'h0, mem[8'(DST + 5)], mem[8'(DST + 4)]}, 32'h00008117);
        check("dir junk", {16'h0, mem[8'(DST + 7)], mem[8'(DST + 6)]}, 32'h00000000);

        // Random messages with a start pulse while busy in word 3.
        load_msgs(1);
        clear_dst();
        run("rand", 17);
        decode_check("rand");
        @(negedge CLK);
        check("done hold", {31'h0, halt}, 32'd1);

        // Re-run from DONE must reproduce the same codewords.
        clear_dst();
        run("rerun", 0);
        decode_check("rerun");

        // Reset asserted during WR_LO of word 5.
        load_msgs(1);
        clear_dst();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        guard = 0;
        while (!(mem_wr_en === 1'b1 && mem_addr === 8'(DST + 10)) && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check("wait wr_lo w5", {31'h0, guard < 100}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid rst wr_en", {31'h0, mem_wr_en}, 32'd0);
        check("mid rst rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("mid rst halt", {31'h0, halt}, 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        clear_dst();
        run("post rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
